// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: opcodes, states, ALU classes
// and datapath mux selects.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE_R = 4'd6,
    S_EXECUTE_I = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // States that touch memory and therefore stretch by the wait-state count.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Memory wait-state counter: counts up while a memory state is active and
// flags the final cycle of that visit.
module wait_counter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  output logic done
);

  localparam int W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST = W'(WAIT_CYCLES);

  logic [W-1:0] count;

  assign done = (count == LAST);

  // Returning to zero on done means back-to-back memory states each start fresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (active && !done) begin
      count <= count + W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV-style datapath, with optional memory
// wait states on every fetch and data access.
//
// state        | meaning
// FETCH        | read instruction at PC, PC <= PC + 4 on last wait cycle
// DECODE       | select next path from opcode, precompute branch target
// MEM_ADR      | rs1 + imm effective address
// MEM_READ     | data memory read at computed address
// MEM_WB       | write loaded data to register file
// MEM_WRITE    | data memory write, strobe on last wait cycle
// EXECUTE_R    | rs1 op rs2
// EXECUTE_I    | rs1 op imm
// ALU_WB       | write ALU out register to register file
// BEQ          | compare rs1/rs2, take branch when zero
// JAL          | link address and jump
// LUI          | pass immediate through ALU
// ILLEGAL      | unsupported opcode, trap held until reset
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter bit ENABLE_LUI  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_select,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_select,
  output logic [1:0] ALU_select_a,
  output logic [1:0] ALU_select_b,
  output logic [1:0] ALU_op,
  output logic       reg_write,
  output logic       trap,
  output logic [3:0] state
);

  state_t cur;
  logic   done;
  logic   mem_active;
  logic   pc_update, branch, ir_en, mem_en, reg_en;

  assign mem_active = is_mem_state(cur);

  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clock  (clock),
    .reset  (reset),
    .active (mem_active),
    .done   (done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:     if (done) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: cur <= S_MEM_ADR;
            OP_R:              cur <= S_EXECUTE_R;
            OP_I:              cur <= S_EXECUTE_I;
            OP_BRANCH:         cur <= S_BEQ;
            OP_JAL:            cur <= S_JAL;
            OP_LUI:            cur <= ENABLE_LUI ? S_LUI : S_ILLEGAL;
            default:           cur <= S_ILLEGAL;
          endcase
        end
        S_MEM_ADR:   cur <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (done) cur <= S_MEM_WB;
        S_MEM_WB:    cur <= S_FETCH;
        S_MEM_WRITE: if (done) cur <= S_FETCH;
        S_EXECUTE_R: cur <= S_ALU_WB;
        S_EXECUTE_I: cur <= S_ALU_WB;
        S_ALU_WB:    cur <= S_FETCH;
        S_BEQ:       cur <= S_FETCH;
        S_JAL:       cur <= S_ALU_WB;
        S_LUI:       cur <= S_ALU_WB;
        S_ILLEGAL:   cur <= S_ILLEGAL;
        default:     cur <= S_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    adr_select    = 1'b0;
    result_select = RES_ALU_OUT;
    ALU_select_a  = SRC_A_PC;
    ALU_select_b  = SRC_B_RS2;
    ALU_op        = ALU_ADD;
    trap          = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_en         = 1'b0;
    mem_en        = 1'b0;
    reg_en        = 1'b0;
    case (cur)
      S_FETCH: begin
        ALU_select_b  = SRC_B_FOUR;
        result_select = RES_ALU_RESULT;
        ir_en         = done;
        pc_update     = done;
      end
      S_DECODE: begin
        ALU_select_a = SRC_A_OLD_PC;
        ALU_select_b = SRC_B_IMM;
      end
      S_MEM_ADR: begin
        ALU_select_a = SRC_A_RS1;
        ALU_select_b = SRC_B_IMM;
      end
      S_MEM_READ:  adr_select = 1'b1;
      S_MEM_WB: begin
        result_select = RES_MEM_DATA;
        reg_en        = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_select = 1'b1;
        mem_en     = done;
      end
      S_EXECUTE_R: begin
        ALU_select_a = SRC_A_RS1;
        ALU_op       = ALU_FUNCT;
      end
      S_EXECUTE_I: begin
        ALU_select_a = SRC_A_RS1;
        ALU_select_b = SRC_B_IMM;
        ALU_op       = ALU_FUNCT;
      end
      S_ALU_WB:    reg_en = 1'b1;
      S_BEQ: begin
        ALU_select_a = SRC_A_RS1;
        ALU_op       = ALU_SUB;
        branch       = 1'b1;
      end
      S_JAL: begin
        ALU_select_a = SRC_A_OLD_PC;
        ALU_select_b = SRC_B_FOUR;
        pc_update    = 1'b1;
      end
      S_LUI: begin
        ALU_select_b = SRC_B_IMM;
        ALU_op       = ALU_PASS_B;
      end
      S_ILLEGAL:   trap = 1'b1;
      default: ;
    endcase
  end

  // Strobes are masked by reset so a pending write dies in the same cycle.
  assign ir_write  = ir_en & ~reset;
  assign mem_write = mem_en & ~reset;
  assign reg_write = reg_en & ~reset;
  assign pc_write  = (pc_update | (branch & zero)) & ~reset;
  assign state     = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table for the
// zero-wait core, plus hand sequences for wait states, reset and traps.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        zero  = 1'b0;
  logic [6:0]  opcode = '0;
  logic [17:0] out0, out2, outn;
  int          checks = 0;
  int          errors = 0;

  // packed view: state | pc_write adr mem_write ir_write | res | A | B | alu_op | reg_write trap
  always #5 clock = ~clock;

  multicycle_controller #(.WAIT_CYCLES(0), .ENABLE_LUI(1'b1)) dut0 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(out0[13]), .adr_select(out0[12]), .mem_write(out0[11]), .ir_write(out0[10]),
    .result_select(out0[9:8]), .ALU_select_a(out0[7:6]), .ALU_select_b(out0[5:4]),
    .ALU_op(out0[3:2]), .reg_write(out0[1]), .trap(out0[0]), .state(out0[17:14]));

  multicycle_controller #(.WAIT_CYCLES(2), .ENABLE_LUI(1'b1)) dut2 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(out2[13]), .adr_select(out2[12]), .mem_write(out2[11]), .ir_write(out2[10]),
    .result_select(out2[9:8]), .ALU_select_a(out2[7:6]), .ALU_select_b(out2[5:4]),
    .ALU_op(out2[3:2]), .reg_write(out2[1]), .trap(out2[0]), .state(out2[17:14]));

  multicycle_controller #(.WAIT_CYCLES(0), .ENABLE_LUI(1'b0)) dutn (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(outn[13]), .adr_select(outn[12]), .mem_write(outn[11]), .ir_write(outn[10]),
    .result_select(outn[9:8]), .ALU_select_a(outn[7:6]), .ALU_select_b(outn[5:4]),
    .ALU_op(outn[3:2]), .reg_write(outn[1]), .trap(outn[0]), .state(outn[17:14]));

  typedef struct packed {
    logic [6:0]  op;
    logic        z;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam logic [31:0] W2_STATES = {S_MEM_WRITE, S_MEM_WRITE, S_MEM_WRITE, S_MEM_ADR,
                                       S_DECODE, S_FETCH, S_FETCH, S_FETCH};
  localparam logic [7:0] W2_IR = 8'b0000_0100;
  localparam logic [7:0] W2_MW = 8'b1000_0000;
  localparam logic [15:0] RST_STATES = {S_DECODE, S_FETCH, S_FETCH, S_FETCH};
  localparam logic [3:0] RST_IR = 4'b0100;

  function automatic logic [17:0] mk(state_t st, logic pcw, logic adr, logic mw, logic irw,
                                     logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] alu, logic rw, logic tr);
    return {st, pcw, adr, mw, irw, res, a, b, alu, rw, tr};
  endfunction

  function automatic vec_t v(logic [6:0] op, logic z, logic [17:0] e);
    return {op, z, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // lw
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_LOAD,   0, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_LOAD,   0, mk(S_MEM_ADR,   0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_MEM_READ,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_MEM_WB,    0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0)));
    // sw
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_STORE,  0, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_STORE,  0, mk(S_MEM_ADR,   0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_MEM_WRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0)));
    // R-type
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_R,      0, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_EXECUTE_R, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_ALU_WB,    0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
    // I-type
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_I,      0, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_LOAD,   0, mk(S_EXECUTE_I, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0)));
    tbl.push_back(v(OP_LOAD,   0, mk(S_ALU_WB,    0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
    // beq taken: zero only matters in BEQ
    tbl.push_back(v(OP_BAD,    1, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BRANCH, 1, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BRANCH, 1, mk(S_BEQ,       1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0)));
    // beq not taken
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BRANCH, 0, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BRANCH, 0, mk(S_BEQ,       0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0)));
    // jal
    tbl.push_back(v(OP_BAD,    1, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_JAL,    1, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    1, mk(S_JAL,       1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    1, mk(S_ALU_WB,    0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
    // lui
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));
    tbl.push_back(v(OP_LUI,    0, mk(S_DECODE,    0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_LUI,       0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11, 0, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_ALU_WB,    0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
    tbl.push_back(v(OP_BAD,    0, mk(S_FETCH,     1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0)));

    // asynchronous reset from an unknown start; zero-wait FETCH must not strobe under reset
    #1 reset = 1'b1;
    #1;
    check("reset_state", out0[17:14], S_FETCH);
    check("reset_trap", out0[0], 1'b0);
    check("reset_strobes", {out0[13], out0[11], out0[10], out0[1]}, 4'b0000);
    check("reset_state_w2", out2[17:14], S_FETCH);
    step();
    reset = 1'b0;

    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      zero   = tbl[i].z;
      #1;
      check($sformatf("vec%0d", i), out0, tbl[i].exp);
      step();
    end

    // WAIT_CYCLES=2 store: 8 cycles, strobes only on last wait cycle
    apply_reset();
    opcode = OP_STORE;
    zero   = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("w2_sw_state_c%0d", c + 1), out2[17:14], W2_STATES[c*4 +: 4]);
      check($sformatf("w2_sw_ir_c%0d", c + 1), out2[10], W2_IR[c]);
      check($sformatf("w2_sw_mw_c%0d", c + 1), out2[11], W2_MW[c]);
      if (c != 7) step();
    end
    check("w2_sw_final_vec", out2, mk(S_MEM_WRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    reset = 1'b1;
    #1;
    check("w2_rst_kills_mw", out2[11], 1'b0);
    check("w2_rst_state", out2[17:14], S_FETCH);
    step();
    reset = 1'b0;
    step();
    check("w2_after_rst_fetch", out2[17:14], S_FETCH);

    // reset during 2nd MEM_WRITE wait cycle, then full FETCH wait sequence
    apply_reset();
    for (int c = 0; c < 6; c++) step();
    check("w2_mid_state", out2[17:14], S_MEM_WRITE);
    check("w2_mid_mw", out2[11], 1'b0);
    reset = 1'b1;
    #1;
    check("w2_mid_rst_state", out2[17:14], S_FETCH);
    check("w2_mid_rst_mw", out2[11], 1'b0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("w2_restart_state_c%0d", c + 1), out2[17:14], RST_STATES[c*4 +: 4]);
      check($sformatf("w2_restart_ir_c%0d", c + 1), out2[10], RST_IR[c]);
      check($sformatf("w2_restart_mw_c%0d", c + 1), out2[11], 1'b0);
      step();
    end

    // ENABLE_LUI=0: lui traps and stays trapped regardless of opcode
    apply_reset();
    opcode = OP_LUI;
    zero   = 1'b1;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      opcode = (c % 2 == 1) ? OP_LOAD : OP_R;
      #1;
      check($sformatf("nolui_illegal_c%0d", c + 1), outn,
            mk(S_ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
      step();
    end
    reset = 1'b1;
    #1;
    check("nolui_rst_state", outn[17:14], S_FETCH);
    check("nolui_rst_trap", outn[0], 1'b0);
    step();
    reset = 1'b0;

    // unknown opcode traps; async reset clears before the next edge
    apply_reset();
    opcode = OP_BAD;
    zero   = 1'b0;
    step();
    step();
    #1;
    check("bad_op_illegal", out0, mk(S_ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    step();
    opcode = OP_LOAD;
    #1;
    check("bad_op_sticky", {out0[17:14], out0[0]}, {S_ILLEGAL, 1'b1});
    reset = 1'b1;
    #1;
    check("bad_op_rst_state", out0[17:14], S_FETCH);
    check("bad_op_rst_trap", out0[0], 1'b0);
    check("bad_op_rst_strobes", {out0[13], out0[10]}, 2'b00);
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, memory wait states added to each FETCH, MEM_READ and MEM_WRITE visit (range 0..15).
REQ-002 Parameter ENABLE_LUI, default 1, lui decode enable; 0 = lui is illegal.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 opcode  in  7  instruction opcode field from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 pc_write  out  1  PC load enable.
REQ-008 adr_select  out  1  memory address mux (0 = PC, 1 = result).
REQ-009 mem_write  out  1  data memory write strobe.
REQ-010 ir_write  out  1  instruction register load.
REQ-011 result_select  out  2  result mux (00 = ALU out reg, 01 = mem data, 10 = ALU result).
REQ-012 ALU_select_a  out  2  ALU A mux (00 = PC, 01 = old PC, 10 = rs1).
REQ-013 ALU_select_b  out  2  ALU B mux (00 = rs2, 01 = immediate, 10 = constant 4).
REQ-014 ALU_op  out  2  ALU class (00 = add, 01 = subtract/compare, 10 = funct-decoded, 11 = pass B).
REQ-015 reg_write  out  1  register file write enable.
REQ-016 trap  out  1  illegal opcode detected, sticky.
REQ-017 state  out  4  current state code, for debug.

Function
REQ-018 Moore FSM; all outputs except pc_write are decoded from state and wait count only; unlisted outputs are 0.
REQ-019 pc_write SHALL equal pc_update OR (branch AND zero), combinational on zero.
REQ-020 FETCH: adr_select=0, A=00, B=10, ALU_op=00, result_select=10; ir_write=1 and pc_update=1 in final wait cycle only -> DECODE.
REQ-021 DECODE: A=01, B=01, ALU_op=00. Next state: 0000011/0100011 -> MEM_ADR; 0110011 -> EXECUTE_R; 0010011 -> EXECUTE_I; 1100011 -> BEQ; 1101111 -> JAL; 0110111 -> LUI if ENABLE_LUI, else ILLEGAL; any other -> ILLEGAL.
REQ-022 MEM_ADR: A=10, B=01, ALU_op=00 -> MEM_READ if opcode 0000011, else MEM_WRITE.
REQ-023 MEM_READ: adr_select=1, result_select=00 -> MEM_WB after wait.
REQ-024 MEM_WB: result_select=01, reg_write=1 -> FETCH.
REQ-025 MEM_WRITE: adr_select=1, result_select=00; mem_write=1 in final wait cycle only -> FETCH.
REQ-026 EXECUTE_R: A=10, B=00, ALU_op=10 -> ALU_WB. EXECUTE_I: A=10, B=01, ALU_op=10 -> ALU_WB.
REQ-027 ALU_WB: result_select=00, reg_write=1 -> FETCH.
REQ-028 BEQ: A=10, B=00, ALU_op=01, result_select=00, branch=1 -> FETCH.
REQ-029 JAL: A=01, B=10, ALU_op=00, result_select=00, pc_update=1 -> ALU_WB.
REQ-030 LUI: B=01, ALU_op=11 -> ALU_WB.
REQ-031 ILLEGAL: trap=1, all write strobes 0, remains until reset.
REQ-032 Wait counter: loads 0 on entering a memory state, increments each cycle, state advances when count == WAIT_CYCLES; counter width max(1, clog2(WAIT_CYCLES+1)).
REQ-033 With WAIT_CYCLES=0, every state lasts exactly one cycle: lw 5, sw 4, R/I 4, beq 3, jal 4, lui 4 cycles.
REQ-034 opcode is sampled only in DECODE and MEM_ADR; changes in other states have no effect.

Reset
REQ-035 reset SHALL force state=FETCH, count=0, and trap=0 immediately, independent of clock.
REQ-036 Reset asserted mid-instruction, including mid-wait, SHALL suppress any pending strobe in the same cycle.
REQ-037 On the first rising edge after reset deassertion, FETCH SHALL begin its full wait sequence.

Structure
REQ-038 Shared package: opcode constants, state encodings, ALU_op codes, and mux select encodings.
REQ-039 One sub-module, wait_counter, parametrised by WAIT_CYCLES, outputs done.

Verification
REQ-040 WAIT_CYCLES=0, opcode 0000011 -> states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB; reg_write=1 only in cycle 5; ir_write=1 only in cycle 1.
REQ-041 WAIT_CYCLES=2, opcode 0100011 -> FETCH held 3 cycles with ir_write only in the 3rd; mem_write=1 only in the 3rd MEM_WRITE cycle; 8 cycles total.
REQ-042 opcode 1100011 -> zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0 and return to FETCH.
REQ-043 opcode 0110111 -> ENABLE_LUI=1: LUI with ALU_op=11 then ALU_WB; ENABLE_LUI=0: ILLEGAL with trap=1 held for 10 cycles.
REQ-044 opcode 1111111 -> ILLEGAL with trap=1; reset asserted -> state=FETCH and trap=0 before the next edge.
REQ-045 Reset pulsed during the 2nd MEM_WRITE wait cycle (WAIT_CYCLES=2) -> mem_write never asserts; FETCH restarts with count=0.
